dmem_mmio_subsystem: RTL and testbench

//   Synthesizable data-side memory subsystem for the pipelined RV32 core: byte-addressed data RAM plus MMIO block
//   (buffered UART TX, status, 64-bit cycle counter, exit register). Parametrised in memory size, MMIO base,

---
 rtl/dmem_mmio_subsystem.sv | 234 +++++++++++++++++++++++
 tb/tb_dmem_mmio_subsystem.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio_subsystem.sv
// Data-side memory subsystem: byte-addressed RAM plus an MMIO window (UART TX FIFO, status,
// 64-bit cycle counter, exit register) behind a valid/ready request and a pipelined response.
module dmem_mmio_subsystem #(
   parameter int unsigned MEM_BYTES     = 262144,
   parameter logic [31:0] MMIO_BASE     = 32'h1000_0000,
   parameter int unsigned READ_LATENCY  = 1,
   parameter int unsigned TX_FIFO_DEPTH = 16,
   // Reset value of the cycle counter; non-zero only to reach the 2^32 boundary quickly.
   parameter logic [63:0] CYCLE_INIT    = 64'd0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   output logic        halt,
   output logic [31:0] exit_code
);

   localparam int unsigned WORDS = MEM_BYTES / 4;
   localparam int unsigned WAW   = $clog2(WORDS);
   localparam int unsigned PW    = $clog2(TX_FIFO_DEPTH);
   localparam logic [32:0] RAM_LIMIT = 33'(MEM_BYTES);
   localparam logic [PW:0] FIFO_FULL = (PW + 1)'(TX_FIFO_DEPTH);

   localparam logic [2:0] OFF_TX     = 3'd0;
   localparam logic [2:0] OFF_STATUS = 3'd1;
   localparam logic [2:0] OFF_CYC_LO = 3'd2;
   localparam logic [2:0] OFF_CYC_HI = 3'd3;
   localparam logic [2:0] OFF_EXIT   = 3'd4;

   // ---------------------------------------------------------------- state
   logic [31:0]   ram [WORDS];
   logic [31:0]   ram_rd_q;
   logic [7:0]    fifo_q [TX_FIFO_DEPTH];
   logic [PW-1:0] wptr_q, rptr_q;
   logic [PW:0]   count_q;
   logic [63:0]   cycle_q;
   logic [31:0]   hi_shadow_q;
   logic          halt_q;
   logic [31:0]   exit_code_q;

   logic          s0_valid_q, s0_err_q, s0_write_q, s0_ram_q;
   logic [2:0]    s0_f3_q;
   logic [1:0]    s0_lane_q;
   logic [31:0]   s0_mmio_q;

   // ---------------------------------------------------------------- decode
   logic          f3_ok, misaligned, hit_ram, hit_mmio, exit_bad, dec_err;
   logic [2:0]    woff;
   logic          tx_push_req, accept, fifo_full, fifo_empty, push, pop;
   logic [WAW-1:0] widx;
   logic [31:0]   wr_data, mmio_rd;
   logic [3:0]    wr_be;

   assign woff     = req_addr[4:2];
   assign widx     = req_addr[WAW+1:2];
   assign hit_ram  = {1'b0, req_addr} < RAM_LIMIT;
   // The window is 32 bytes, so a 32-byte-aligned base matches on the upper address bits.
   assign hit_mmio = req_addr[31:5] == MMIO_BASE[31:5];

   always_comb begin
      f3_ok = req_write ? (req_funct3 inside {3'b000, 3'b001, 3'b010})
                        : (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      misaligned = (req_funct3[1:0] == 2'd1 && req_addr[0]) ||
                   (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'd0);
      exit_bad   = req_write && hit_mmio && woff == OFF_EXIT && req_funct3 != 3'b010;
      dec_err    = !f3_ok || misaligned || !(hit_ram || hit_mmio) || exit_bad;
   end

   assign fifo_full   = count_q == FIFO_FULL;
   assign fifo_empty  = count_q == '0;
   assign tx_push_req = req_write && hit_mmio && woff == OFF_TX && !dec_err;
   // A full FIFO stalls TX stores even when the head is popped in the same cycle.
   assign req_ready   = reset_n && !halt_q && !(req_valid && tx_push_req && fifo_full);
   assign accept      = req_valid && req_ready;
   assign push        = accept && tx_push_req;
   assign pop         = !fifo_empty && tx_ready;

   always_comb begin
      case (req_funct3[1:0])
         2'd0: begin
            wr_data = {4{req_wdata[7:0]}};
            wr_be   = 4'b0001 << req_addr[1:0];
         end
         2'd1: begin
            wr_data = {2{req_wdata[15:0]}};
            wr_be   = req_addr[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            wr_data = req_wdata;
            wr_be   = 4'b1111;
         end
      endcase
   end

   always_comb begin
      case (woff)
         OFF_STATUS: mmio_rd = {8'd0, 16'(count_q), 6'd0, fifo_full, fifo_empty};
         OFF_CYC_LO: mmio_rd = cycle_q[31:0];
         OFF_CYC_HI: mmio_rd = hi_shadow_q;
         OFF_EXIT:   mmio_rd = exit_code_q;
         default:    mmio_rd = 32'd0;
      endcase
   end

   // ---------------------------------------------------------------- RAM (not reset)
   always_ff @(posedge clk) begin
      if (accept && req_write && hit_ram && !dec_err) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) ram[widx][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
      if (accept && !req_write) ram_rd_q <= ram[widx];
   end

   // ---------------------------------------------------------------- TX FIFO
   always_ff @(posedge clk) begin
      if (push) fifo_q[wptr_q] <= req_wdata[7:0];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) wptr_q <= wptr_q + PW'(1);
         if (pop)  rptr_q <= rptr_q + PW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + (PW + 1)'(1);
            2'b01:   count_q <= count_q - (PW + 1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign tx_valid = !fifo_empty;
   assign tx_data  = fifo_q[rptr_q];

   // ---------------------------------------------------------------- counter, halt, exit
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cycle_q     <= CYCLE_INIT;
         hi_shadow_q <= 32'd0;
         halt_q      <= 1'b0;
         exit_code_q <= 32'd0;
      end else begin
         if (!halt_q) cycle_q <= cycle_q + 64'd1;
         if (accept && !req_write && !dec_err && hit_mmio && woff == OFF_CYC_LO) begin
            hi_shadow_q <= cycle_q[63:32];
         end
         if (accept && req_write && !dec_err && hit_mmio && woff == OFF_EXIT) begin
            halt_q      <= 1'b1;
            exit_code_q <= req_wdata;
         end
      end
   end

   assign halt      = halt_q;
   assign exit_code = exit_code_q;

   // ---------------------------------------------------------------- response stage 0
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s0_valid_q <= 1'b0;
         s0_err_q   <= 1'b0;
         s0_write_q <= 1'b0;
         s0_ram_q   <= 1'b0;
         s0_f3_q    <= 3'd0;
         s0_lane_q  <= 2'd0;
         s0_mmio_q  <= 32'd0;
      end else begin
         s0_valid_q <= accept;
         if (accept) begin
            s0_err_q   <= dec_err;
            s0_write_q <= req_write;
            s0_ram_q   <= hit_ram;
            s0_f3_q    <= req_funct3;
            s0_lane_q  <= req_addr[1:0];
            s0_mmio_q  <= mmio_rd;
         end
      end
   end

   logic [31:0] fmt_word, fmt_shift, fmt_rdata;
   logic        fmt_valid, fmt_err;

   always_comb begin
      fmt_word  = s0_ram_q ? ram_rd_q : s0_mmio_q;
      fmt_shift = fmt_word >> {s0_lane_q, 3'b000};
      case (s0_f3_q)
         3'b000:  fmt_rdata = {{24{fmt_shift[7]}}, fmt_shift[7:0]};
         3'b001:  fmt_rdata = {{16{fmt_shift[15]}}, fmt_shift[15:0]};
         3'b010:  fmt_rdata = fmt_word;
         3'b100:  fmt_rdata = {24'd0, fmt_shift[7:0]};
         3'b101:  fmt_rdata = {16'd0, fmt_shift[15:0]};
         default: fmt_rdata = 32'd0;
      endcase
      if (!s0_valid_q || s0_err_q || s0_write_q) fmt_rdata = 32'd0;
      fmt_valid = s0_valid_q;
      fmt_err   = s0_valid_q && s0_err_q;
   end

   // ---------------------------------------------------------------- latency pipe
   if (READ_LATENCY == 1) begin : g_lat1
      assign rsp_valid = fmt_valid;
      assign rsp_err   = fmt_err;
      assign rsp_rdata = fmt_rdata;
   end else begin : g_pipe
      logic [33:0] pipe_q [READ_LATENCY-1];

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            for (int i = 0; i < int'(READ_LATENCY) - 1; i++) pipe_q[i] <= '0;
         end else begin
            pipe_q[0] <= {fmt_valid, fmt_err, fmt_rdata};
            for (int i = 1; i < int'(READ_LATENCY) - 1; i++) pipe_q[i] <= pipe_q[i-1];
         end
      end

      assign {rsp_valid, rsp_err, rsp_rdata} = pipe_q[READ_LATENCY-2];
   end

endmodule

// File: tb/tb_dmem_mmio_subsystem.sv
// Scoreboard bench for dmem_mmio_subsystem: directed requests push expected responses,
// separate monitors check rsp_* and the UART byte stream.
module tb_dmem_mmio_subsystem;

   localparam int unsigned LAT    = 3;
   localparam logic [31:0] MB     = 32'h1000_0000;
   localparam logic [31:0] TX     = MB + 32'h00;
   localparam logic [31:0] STATUS = MB + 32'h04;
   localparam logic [31:0] CYC_LO = MB + 32'h08;
   localparam logic [31:0] CYC_HI = MB + 32'h0C;
   localparam logic [31:0] EXIT   = MB + 32'h10;
   localparam logic [63:0] INIT   = 64'h0000_0000_FFFF_FFFA;

   localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
   localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid, req_ready, req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic        tx_valid, tx_ready;
   logic [7:0]  tx_data;
   logic        halt;
   logic [31:0] exit_code;

   dmem_mmio_subsystem #(
      .MEM_BYTES    (262144),
      .MMIO_BASE    (MB),
      .READ_LATENCY (LAT),
      .TX_FIFO_DEPTH(16),
      .CYCLE_INIT   (INIT)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_funct3(req_funct3),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .tx_valid  (tx_valid),
      .tx_data   (tx_data),
      .tx_ready  (tx_ready),
      .halt      (halt),
      .exit_code (exit_code)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   logic [7:0]  txq[$];
   int          tests = 0;
   int          fails = 0;
   int          cyc_tb = 0;
   logic [63:0] mcnt;
   logic        mhalt;
   logic        exit_flag = 1'b0;
   logic [31:0] mhi = 32'd0;
   logic [63:0] frozen;

   // Reference cycle counter: counts every edge out of reset, stops after the EXIT accept edge.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mcnt  <= INIT;
         mhalt <= 1'b0;
      end else begin
         if (!mhalt) mcnt <= mcnt + 64'd1;
         if (exit_flag) mhalt <= 1'b1;
      end
   end

   always @(posedge clk) cyc_tb <= cyc_tb + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_exp(input logic [31:0] er, input logic ee);
      exp_t e;
      e.rdata = er;
      e.err   = ee;
      e.cyc   = cyc_tb + LAT;
      sb.push_back(e);
   endtask

   // kind: 0 = fixed expectation, 1 = CYCLE_LO from model, 2 = CYCLE_HI from model shadow
   task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] er, input logic ee,
                        input int kind);
      bit ok;
      logic [31:0] x;
      @(negedge clk);
      req_valid  = 1'b1;
      req_write  = wr;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      #1;
      ok = 0;
      for (int k = 0; k < 64; k++) begin
         if (req_ready) begin
            ok = 1;
            break;
         end
         @(negedge clk);
         #1;
      end
      if (!ok) begin
         chk("accept_timeout", 64'(req_ready), 64'd1);
         req_valid = 1'b0;
         return;
      end
      x = er;
      if (kind == 1) begin
         x   = mcnt[31:0];
         mhi = mcnt[63:32];
      end else if (kind == 2) begin
         x = mhi;
      end
      push_exp(x, ee);
      if (wr && a == EXIT && f3 == SW && !ee) exit_flag = 1'b1;
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n   = 1'b0;
      req_valid = 1'b0;
      sb.delete();
      exit_flag = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_halt", 64'(halt), 64'd0);
      chk("rst_exit_code", 64'(exit_code), 64'd0);
      chk("rst_tx_valid", 64'(tx_valid), 64'd0);
      reset_n = 1'b1;
   endtask

   // Response monitor
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (rsp_valid) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_rsp: got rdata %h err %b, expected no response",
                     rsp_rdata, rsp_err);
         end else begin
            e = sb.pop_front();
            chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
            chk("rsp_err", 64'(rsp_err), 64'(e.err));
            chk("rsp_latency", 64'(cyc_tb), 64'(e.cyc));
         end
      end
   end

   // UART monitor: a byte leaves at the coming edge when tx_valid && tx_ready
   always @(negedge clk) begin
      #1;
      if (reset_n && tx_valid && tx_ready) begin
         if (txq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_tx: got %h, expected none", tx_data);
         end else begin
            chk("tx_data", 64'(tx_data), 64'(txq.pop_front()));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n    = 1'b0;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_funct3 = 3'd0;
      req_addr   = 32'd0;
      req_wdata  = 32'd0;
      tx_ready   = 1'b0;
      repeat (3) @(negedge clk);
      req_valid = 1'b1;
      #1;
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
      chk("rst_rsp_err", 64'(rsp_err), 64'd0);
      chk("rst_tx_valid", 64'(tx_valid), 64'd0);
      chk("rst_halt", 64'(halt), 64'd0);
      chk("rst_exit_code", 64'(exit_code), 64'd0);
      req_valid = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;

      // Coherent LO/HI pairs straddling the 2^32 boundary
      for (int i = 0; i < 5; i++) begin
         issue(0, LW, CYC_LO, 0, 0, 0, 1);
         issue(0, LW, CYC_HI, 0, 0, 0, 2);
      end

      // Loads with extension, store-then-load, back-to-back
      issue(1, SW, 32'h100, 32'hDEAD_BEEF, 0, 0, 0);
      issue(1, SW, 32'h104, 32'h0, 0, 0, 0);
      issue(0, LB, 32'h103, 0, 32'hFFFF_FFDE, 0, 0);
      issue(0, LBU, 32'h103, 0, 32'h0000_00DE, 0, 0);
      issue(0, LH, 32'h102, 0, 32'hFFFF_DEAD, 0, 0);
      issue(0, LHU, 32'h102, 0, 32'h0000_DEAD, 0, 0);
      issue(0, LW, 32'h100, 0, 32'hDEAD_BEEF, 0, 0);
      issue(1, SB, 32'h101, 32'h0000_0055, 0, 0, 0);
      issue(0, LW, 32'h100, 0, 32'hDEAD_55EF, 0, 0);
      issue(1, SH, 32'h106, 32'h0000_ABCD, 0, 0, 0);
      issue(0, LW, 32'h104, 0, 32'hABCD_0000, 0, 0);
      issue(0, LB, 32'h106, 0, 32'hFFFF_FFCD, 0, 0);
      issue(0, LH, 32'h104, 0, 32'h0000_0000, 0, 0);

      // Error cases and decode boundaries
      issue(0, LH, 32'h101, 0, 0, 1, 0);
      issue(1, SW, 32'h2000_0000, 32'h1111_1111, 0, 1, 0);
      issue(1, SW, 32'h102, 32'h1111_1111, 0, 1, 0);
      issue(0, LW, 32'h100, 0, 32'hDEAD_55EF, 0, 0);
      issue(0, 3'b011, 32'h100, 0, 0, 1, 0);
      issue(1, 3'b100, 32'h100, 32'h2222_2222, 0, 1, 0);
      issue(0, LW, 32'h100, 0, 32'hDEAD_55EF, 0, 0);
      issue(0, LW, 32'h0004_0000, 0, 0, 1, 0);
      issue(1, SW, 32'h0003_FFFC, 32'h1234_5678, 0, 0, 0);
      issue(0, LW, 32'h0003_FFFC, 0, 32'h1234_5678, 0, 0);
      issue(0, LB, 32'h0FFF_FFFF, 0, 0, 1, 0);
      issue(0, LW, MB + 32'h20, 0, 0, 1, 0);
      issue(0, LW, MB + 32'h14, 0, 0, 0, 0);
      issue(1, SB, EXIT, 32'h7, 0, 1, 0);
      issue(0, LW, EXIT, 0, 0, 0, 0);
      idle(1);
      chk("no_halt_after_bad_exit", 64'(halt), 64'd0);

      // UART FIFO fill, full stall, single pop
      issue(0, LW, STATUS, 0, 32'h0000_0001, 0, 0);
      for (int i = 0; i < 16; i++) begin
         txq.push_back(8'h10 + 8'(i));
         issue(1, SB, TX, 32'hAB00 + 32'(i) + 32'h10, 0, 0, 0);
      end
      idle(1);
      #1;
      chk("tx_valid_full", 64'(tx_valid), 64'd1);
      chk("tx_head_stable", 64'(tx_data), 64'h10);
      @(negedge clk);
      req_valid  = 1'b1;
      req_write  = 1'b1;
      req_funct3 = SB;
      req_addr   = TX;
      req_wdata  = 32'h20;
      #1;
      chk("full_stall", 64'(req_ready), 64'd0);
      tx_ready = 1'b1;
      #1;
      chk("full_stall_with_pop", 64'(req_ready), 64'd0);
      @(negedge clk);
      tx_ready = 1'b0;
      #1;
      chk("ready_after_pop", 64'(req_ready), 64'd1);
      push_exp(0, 0);
      txq.push_back(8'h20);
      @(posedge clk);
      issue(0, LW, STATUS, 0, 32'h0000_1002, 0, 0);
      idle(1);
      tx_ready = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         #2;
         if (!tx_valid) break;
      end
      tx_ready = 1'b0;
      chk("tx_drained", 64'(tx_valid), 64'd0);
      chk("txq_empty", 64'(txq.size()), 64'd0);

      // EXIT, halt, frozen counter, in-flight completion
      issue(1, SW, EXIT, 32'h2A, 0, 0, 0);
      #1;
      chk("halt", 64'(halt), 64'd1);
      chk("exit_code", 64'(exit_code), 64'd42);
      @(negedge clk);
      req_valid  = 1'b1;
      req_write  = 1'b0;
      req_funct3 = LW;
      req_addr   = 32'h100;
      #1;
      chk("halt_req_ready", 64'(req_ready), 64'd0);
      frozen = dut.cycle_q;
      repeat (3) @(negedge clk);
      chk("cycle_frozen", dut.cycle_q, frozen);
      chk("cycle_model", dut.cycle_q, mcnt);
      req_valid = 1'b0;
      repeat (LAT + 2) @(negedge clk);
      chk("inflight_done", 64'(sb.size()), 64'd0);

      // Reset clears halt; reset mid-load drops the response; RAM keeps its contents
      do_reset();
      issue(0, LW, 32'h100, 0, 32'hDEAD_55EF, 0, 0);
      @(negedge clk);
      reset_n   = 1'b0;
      req_valid = 1'b0;
      sb.delete();
      repeat (4) @(negedge clk);
      chk("midload_rsp_valid", 64'(rsp_valid), 64'd0);
      reset_n = 1'b1;
      repeat (LAT + 3) @(negedge clk);
      issue(0, LW, 32'h100, 0, 32'hDEAD_55EF, 0, 0);
      idle(LAT + 3);
      chk("sb_empty", 64'(sb.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
